// File: rtl/cenn_pkg.sv
// Shared CeNN datapath definitions: fixed-point format, saturation limits
// and the divider state encoding.
package cenn_pkg;

  localparam int unsigned WIDTH    = 15;
  localparam int unsigned FRAC_BIT = 9;

  typedef logic signed [WIDTH-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = 15'h3FFF;
  localparam fixed_t FIXED_MIN = 15'h4000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

endpackage

// File: rtl/divi_if.sv
// Start/done handshake bundle between cell-update logic and the divider.
interface divi_if #(
  parameter int unsigned width = 15
);
  logic             start;
  logic [width-1:0] input_a;
  logic [width-1:0] input_b;
  logic             busy;
  logic             done;
  logic [width-1:0] out;
  logic             div_by_zero;

  modport master (
    output start, input_a, input_b,
    input  busy, done, out, div_by_zero
  );

  modport slave (
    input  start, input_a, input_b,
    output busy, done, out, div_by_zero
  );
endinterface

// File: rtl/divi.sv
// Sequential signed fixed-point restoring divider, one quotient bit per clock,
// with saturation and divide-by-zero reporting.
module divi
  import cenn_pkg::*;
#(
  parameter int unsigned width          = WIDTH,
  parameter int unsigned fractional_bit = FRAC_BIT
) (
  input logic   clk,
  input logic   rst,
  divi_if.slave bus
);

  localparam int unsigned DW = width + fractional_bit;
  localparam int unsigned CW = $clog2(DW);
  localparam logic [width-1:0] MAX_V = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] MIN_V = {1'b1, {(width-1){1'b0}}};

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_dividend;
  logic [width:0]   r_rem;
  logic [DW-1:0]    r_quo;
  logic [width-1:0] r_bmag;
  logic             r_neg;
  logic             r_a_neg;
  logic             r_b_zero;
  logic [width-1:0] r_out;
  logic             r_done;
  logic             r_dbz;

  logic [width-1:0] w_amag;
  logic [width-1:0] w_bmag;
  logic [width+1:0] w_shift;
  logic [width+1:0] w_diff;
  logic             w_ge;
  logic             w_ovf_pos;
  logic             w_ovf_neg;
  logic [width-1:0] w_fix_out;
  logic             w_busy;

  // Two's-complement negation of the most negative value maps onto itself,
  // which as an unsigned magnitude is exactly 2^(width-1).
  assign w_amag = bus.input_a[width-1] ? -bus.input_a : bus.input_a;
  assign w_bmag = bus.input_b[width-1] ? -bus.input_b : bus.input_b;

  assign w_shift = {r_rem, r_dividend[DW-1]};
  assign w_diff  = w_shift - {2'b00, r_bmag};
  assign w_ge    = ~w_diff[width+1];

  assign w_ovf_pos = |r_quo[DW-1:width-1];
  assign w_ovf_neg = (|r_quo[DW-1:width]) | (r_quo[width-1] & (|r_quo[width-2:0]));

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_fix_out    = r_quo[width-1:0];
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.input_b == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = FIX;
        end
      end
      FIX: begin
        w_busy       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase

    if (r_b_zero) begin
      w_fix_out = r_a_neg ? MIN_V : MAX_V;
    end else if (r_neg) begin
      w_fix_out = w_ovf_neg ? MIN_V : -r_quo[width-1:0];
    end else begin
      w_fix_out = w_ovf_pos ? MAX_V : r_quo[width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_bmag     <= '0;
      r_neg      <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dividend <= {w_amag, {fractional_bit{1'b0}}};
            r_rem      <= '0;
            r_quo      <= '0;
            r_bmag     <= w_bmag;
            r_a_neg    <= bus.input_a[width-1];
            r_neg      <= bus.input_a[width-1] ^ bus.input_b[width-1];
            r_b_zero   <= (bus.input_b == '0);
            r_cnt      <= CW'(DW - 1);
          end
        end
        CALC: begin
          r_dividend <= {r_dividend[DW-2:0], 1'b0};
          r_rem      <= w_ge ? w_diff[width:0] : w_shift[width:0];
          r_quo      <= {r_quo[DW-2:0], w_ge};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          r_out  <= w_fix_out;
          r_dbz  <= r_b_zero;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.out         = r_out;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divi.sv
// Self-checking bench for divi: table-driven vectors through a scoreboard,
// plus handshake corner sequences (dropped start, back-to-back, reset abort).
module tb_divi;
  import cenn_pkg::*;

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic [14:0] exp_out;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divi_if #(.width(WIDTH)) bus ();

  divi #(.width(WIDTH), .fractional_bit(FRAC_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t sb[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t model(input logic [14:0] a, input logic [14:0] b);
    vec_t v;
    int sa, sb_, ma, mb, q;
    sa = int'($signed(a));
    sb_ = int'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb_ < 0) ? -sb_ : sb_;
    v.a = a;
    v.b = b;
    if (mb == 0) begin
      v.exp_out = (sa < 0) ? 15'h4000 : 15'h3FFF;
      v.exp_dbz = 1'b1;
      v.exp_lat = 1;
    end else begin
      q = (ma * 512) / mb;
      if ((sa < 0) != (sb_ < 0)) q = -q;
      if (q > 16383) q = 16383;
      if (q < -16384) q = -16384;
      v.exp_out = q[14:0];
      v.exp_dbz = 1'b0;
      v.exp_lat = 25;
    end
    return v;
  endfunction

  // Drives one division; inj_at > 0 pulses a competing start at that cycle.
  task automatic run_one(input vec_t v, input string name, input int inj_at);
    vec_t e;
    int   n;
    bit   got;
    bus.start   = 1'b1;
    bus.input_a = v.a;
    bus.input_b = v.b;
    sb.push_back(v);
    tick();
    bus.start   = 1'b0;
    bus.input_a = 15'h1234;
    bus.input_b = 15'h0005;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    n   = 0;
    got = 0;
    while (n < 40 && !got) begin
      if (inj_at > 0 && n == inj_at - 1) begin
        bus.start   = 1'b1;
        bus.input_a = 15'h0200;
        bus.input_b = 15'h0000;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
      if (bus.done) got = 1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_out"}, 32'(bus.out), 32'(e.exp_out));
      check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(e.exp_dbz));
      check({name, "_lat"}, 32'(n), 32'(e.exp_lat));
      check({name, "_busy_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int   ndone;
    vec_t v;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.input_a = '0;
    bus.input_b = '0;
    tick();
    tick();
    check("rst_out",  32'(bus.out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    tbl.push_back('{15'h0600, 15'h0400, 15'h0300, 1'b0, 25});
    tbl.push_back('{15'h7A00, 15'h0400, 15'h7D00, 1'b0, 25});
    tbl.push_back('{15'h0200, 15'h0600, 15'h00AA, 1'b0, 25});
    tbl.push_back('{15'h0200, 15'h7A00, 15'h7F56, 1'b0, 25});
    tbl.push_back('{15'h3FFF, 15'h0001, 15'h3FFF, 1'b0, 25});
    tbl.push_back('{15'h4000, 15'h0200, 15'h4000, 1'b0, 25});
    tbl.push_back('{15'h4000, 15'h7E00, 15'h3FFF, 1'b0, 25});
    tbl.push_back('{15'h0600, 15'h0000, 15'h3FFF, 1'b1, 1});
    tbl.push_back('{15'h7A00, 15'h0000, 15'h4000, 1'b1, 1});
    tbl.push_back('{15'h7FFF, 15'h4000, 15'h0000, 1'b0, 25});
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(model(15'($urandom_range(0, 32767)), 15'($urandom_range(1, 32767))));
    end
    tbl.push_back(model(15'h1357, 15'h0003));
    tbl.push_back(model(15'h6ACE, 15'h0011));

    // Each new start is driven in the cycle done is high: back-to-back.
    for (int i = 0; i < tbl.size(); i++) begin
      run_one(tbl[i], $sformatf("vec%0d", i), 0);
    end

    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("out_held", 32'(bus.out), 32'(tbl[tbl.size()-1].exp_out));

    v = '{15'h0600, 15'h0400, 15'h0300, 1'b0, 25};
    run_one(v, "drop_start", 10);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("drop_no_extra_done", 32'(ndone), 32'd0);
    check("drop_out_kept", 32'(bus.out), 32'h0300);

    bus.start   = 1'b1;
    bus.input_a = 15'h0200;
    bus.input_b = 15'h0600;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out",  32'(bus.out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_out_after", 32'(bus.out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
